// File: rtl/resp_tx_pkg.sv
// resp_tx shared types: opcodes, upstates, status codes
// and the packer state encoding.
package resp_tx_pkg;

  localparam int OPC_SZ   = 3;
  localparam int ID_SZ    = 28;
  localparam int BUD_WID  = 32;
  localparam int BRAM_DEP = 512;
  localparam int EXT_BIT  = 28;

  typedef enum logic [2:0] {
    DEL = 3'd0,
    ADD = 3'd1,
    SET = 3'd2,
    RDC = 3'd3,
    MSC = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2,
    DONE   = 2'd3
  } upstate_e;

  localparam logic [27:0] RDY = 28'd0;
  localparam logic [27:0] BSY = 28'd1;
  localparam logic [27:0] FLL = 28'd2;
  localparam logic [27:0] UNF = 28'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } pk_state_e;

  function automatic logic [31:0] sts_word(
    input logic [27:0] code
  );
    return {MSC, 1'b1, code};
  endfunction

endpackage

// File: rtl/resp_tx_if.sv
// Engine record handshake plus host read port
// and status outputs of resp_tx.
interface resp_tx_if
  import resp_tx_pkg::*;
#(
  parameter int DEPTH = BRAM_DEP
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic          eng_vld;
  logic          eng_rdy;
  logic [2:0]    eng_opc;
  logic [27:0]   eng_id;
  logic [1:0]    eng_st;
  logic          rd_req;
  logic          rd_ack;
  logic [31:0]   rd_data;
  logic [27:0]   sts;
  logic [FW-1:0] fill;

  modport master (
    output eng_vld, eng_opc, eng_id,
    output eng_st, rd_req,
    input  eng_rdy, rd_ack, rd_data,
    input  sts, fill
  );

  modport slave (
    input  eng_vld, eng_opc, eng_id,
    input  eng_st, rd_req,
    output eng_rdy, rd_ack, rd_data,
    output sts, fill
  );

endinterface

// File: rtl/resp_fifo.sv
// Single-clock BRAM FIFO with registered read
// and an occupancy counter spanning 0..DEPTH.
module resp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             q,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [$clog2(DEPTH):0]   fill_nxt,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign full  = fill == (AW+1)'(DEPTH);
  assign empty = fill == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;

  always_comb begin
    fill_nxt = fill;
    unique case ({wr, rd})
      2'b10:   fill_nxt = fill + ONE;
      2'b01:   fill_nxt = fill - ONE;
      default: fill_nxt = fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      q    <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) begin
        rptr <= rptr + AW'(1);
        q    <= mem[rptr];
      end
      fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/resp_tx.sv
// Packs engine completion records into response words,
// buffers them and answers host register reads.
module resp_tx
  import resp_tx_pkg::*;
#(
  parameter int BUD_WID = 32,
  parameter int OPC_SZ  = 3,
  parameter int ID_SZ   = 28,
  parameter int DEPTH   = BRAM_DEP
) (
  input logic     clk,
  input logic     rst,
  resp_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  if (BUD_WID != OPC_SZ + 1 + ID_SZ) begin : g_chk
    $error("resp_tx word width mismatch");
  end

  pk_state_e          state;
  pk_state_e          state_nxt;
  logic [1:0]         st_q;
  logic               rdy;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               ack_q;
  logic               unf_q;
  logic [27:0]        sts_q;
  logic [27:0]        sts_nxt;
  logic [BUD_WID-1:0] wdata;
  logic [BUD_WID-1:0] q;
  logic [AW:0]        fill_nxt;

  resp_fifo #(
    .W     (BUD_WID),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wdata    (wdata),
    .pop      (pop),
    .q        (q),
    .fill     (bus.fill),
    .fill_nxt (fill_nxt),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      st_q  <= '0;
    end else begin
      state <= state_nxt;
      if (rdy && bus.eng_vld) st_q <= bus.eng_st;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (bus.eng_vld && rdy && bus.eng_opc == RDC)
          state_nxt = SECOND;
      SECOND:
        if (!full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy   = 1'b0;
    push  = 1'b0;
    wdata = {bus.eng_opc, 1'b0, bus.eng_id};
    unique case (state)
      IDLE: begin
        rdy  = ~full & ~rst;
        push = bus.eng_vld & rdy;
      end
      SECOND: begin
        push  = ~full;
        wdata = {RDC, 1'b1, {(ID_SZ-2){1'b0}}, st_q};
      end
      default: ;
    endcase
  end

  assign pop = bus.rd_req & ~empty;

  // status looks at next-cycle occupancy so it moves with fill
  always_comb begin
    sts_nxt = RDY;
    if (fill_nxt == (AW+1)'(DEPTH))
      sts_nxt = FLL;
    else if (fill_nxt != '0 || state_nxt == SECOND)
      sts_nxt = BSY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      unf_q <= 1'b0;
      sts_q <= RDY;
    end else begin
      ack_q <= bus.rd_req;
      if (bus.rd_req) unf_q <= empty;
      sts_q <= sts_nxt;
    end
  end

  assign bus.eng_rdy = rdy;
  assign bus.rd_ack  = ack_q;
  assign bus.sts     = sts_q;
  assign bus.rd_data = unf_q ? sts_word(UNF) : q;

endmodule
